// File: rtl/plab2_proc_bypass_pkg.sv
// Shared definitions for the bypass/scoreboard slice: select encoding
// and a width helper used to size stage-index and select fields.
package plab2_proc_bypass_pkg;

  // byp_sel value meaning "operand comes from the register file";
  // stage s is encoded as s+1.
  localparam int unsigned c_byp_sel_regfile = 0;

  // Bits needed to encode values 0..v-1; never less than 1 so that
  // degenerate single-stage builds still get a legal field width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/plab2_proc_bypass_scoreboard_if.sv
// Bundle between the D-stage control/datapath and the bypass scoreboard.
//   master: pipeline side (drives issue, stage control, read ports, data)
//   slave : scoreboard side (drives rd_data, byp_sel, stall_D, pending)
// Vector fields are flat: port p at [p*W +: W], stage s at [s*W +: W].
interface plab2_proc_bypass_scoreboard_if
  import plab2_proc_bypass_pkg::*;
#(
  parameter int unsigned p_num_stages   = 3,
  parameter int unsigned p_num_rd_ports = 2,
  parameter int unsigned p_addr_nbits   = 5,
  parameter int unsigned p_data_nbits   = 32
);
  localparam int unsigned c_stage_nbits = clog2(p_num_stages);
  localparam int unsigned c_sel_nbits   = clog2(p_num_stages + 1);

  logic                                    domain;
  logic                                    issue_val;
  logic                                    issue_wen;
  logic [p_addr_nbits-1:0]                 issue_waddr;
  logic [c_stage_nbits-1:0]                issue_rdy_stage;
  logic                                    issue_long;
  logic [p_num_stages-1:0]                 stage_en;
  logic [p_num_stages-1:0]                 squash;
  logic [p_num_rd_ports-1:0]               rd_val;
  logic [p_num_rd_ports*p_addr_nbits-1:0]  rd_addr;
  logic [p_num_rd_ports*p_data_nbits-1:0]  rf_rdata;
  logic [p_num_stages*p_data_nbits-1:0]    byp_data;
  logic                                    long_wb_val;
  logic [p_addr_nbits-1:0]                 long_wb_addr;
  logic [p_num_rd_ports*p_data_nbits-1:0]  rd_data;
  logic [p_num_rd_ports*c_sel_nbits-1:0]   byp_sel;
  logic                                    stall_D;
  logic [(1<<p_addr_nbits)-1:0]            pending;

  modport master (
    output domain, issue_val, issue_wen, issue_waddr, issue_rdy_stage,
           issue_long, stage_en, squash, rd_val, rd_addr, rf_rdata,
           byp_data, long_wb_val, long_wb_addr,
    input  rd_data, byp_sel, stall_D, pending
  );

  modport slave (
    input  domain, issue_val, issue_wen, issue_waddr, issue_rdy_stage,
           issue_long, stage_en, squash, rd_val, rd_addr, rf_rdata,
           byp_data, long_wb_val, long_wb_addr,
    output rd_data, byp_sel, stall_D, pending
  );

endinterface

// File: rtl/plab2_proc_bypass_scoreboard_match.sv
// Priority matcher for one read port over the in-flight write entries.
//   ent_*    : per-stage entry fields (stage 0 = X, youngest)
//   rd_addr  : register this port reads
//   rf_rdata : regfile value used when nothing in flight matches
//   byp_data : per-stage result data
//   sel      : 0 = regfile, s+1 = stage s
//   hazard   : youngest match exists but its result is not yet ready
//   data     : forwarded operand
module plab2_proc_bypass_match
  import plab2_proc_bypass_pkg::*;
#(
  parameter int unsigned p_num_stages  = 3,
  parameter int unsigned p_addr_nbits  = 5,
  parameter int unsigned p_data_nbits  = 32,
  parameter int unsigned p_stage_nbits = 2,
  parameter int unsigned p_sel_nbits   = 2
)(
  input  logic [p_num_stages-1:0]                    ent_val,
  input  logic [p_num_stages-1:0][p_addr_nbits-1:0]  ent_waddr,
  input  logic [p_num_stages-1:0][p_stage_nbits-1:0] ent_rdy,
  input  logic [p_addr_nbits-1:0]                    rd_addr,
  input  logic [p_data_nbits-1:0]                    rf_rdata,
  input  logic [p_num_stages-1:0][p_data_nbits-1:0]  byp_data,
  output logic [p_sel_nbits-1:0]                     sel,
  output logic                                       hazard,
  output logic [p_data_nbits-1:0]                    data
);

  logic found;

  always_comb begin
    sel    = p_sel_nbits'(c_byp_sel_regfile);
    data   = rf_rdata;
    hazard = 1'b0;
    found  = 1'b0;
    // Scan young to old; the first hit shadows every older write.
    for (int unsigned s = 0; s < p_num_stages; s++) begin
      if (!found && ent_val[s] && (ent_waddr[s] == rd_addr) && (rd_addr != '0)) begin
        found  = 1'b1;
        sel    = p_sel_nbits'(s + 1);
        data   = byp_data[s];
        hazard = (32'(ent_rdy[s]) > s);
      end
    end
  end

endmodule

// File: rtl/plab2_proc_bypass_scoreboard.sv
// Operand-forwarding and hazard unit for the D stage.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of plab2_proc_bypass_scoreboard_if
// Keeps a per-stage shift register of in-flight pipeline writes and a
// pending-bit vector for long-latency destinations; produces forwarded
// operands, bypass selects and stall_D.
module plab2_proc_bypass_scoreboard
  import plab2_proc_bypass_pkg::*;
#(
  parameter int unsigned p_num_stages   = 3,
  parameter int unsigned p_num_rd_ports = 2,
  parameter int unsigned p_addr_nbits   = 5,
  parameter int unsigned p_data_nbits   = 32
)(
  input logic                          clk,
  input logic                          reset,
  plab2_proc_bypass_scoreboard_if.slave bus
);

  localparam int unsigned S = p_num_stages;
  localparam int unsigned P = p_num_rd_ports;
  localparam int unsigned A = p_addr_nbits;
  localparam int unsigned D = p_data_nbits;
  localparam int unsigned c_stage_nbits = clog2(S);
  localparam int unsigned c_sel_nbits   = clog2(S + 1);

  logic [S-1:0]                    ent_val;
  logic [S-1:0][A-1:0]             ent_waddr;
  logic [S-1:0][c_stage_nbits-1:0] ent_rdy;

  logic [S-1:0]                    up_val;
  logic [S-1:0][A-1:0]             up_waddr;
  logic [S-1:0][c_stage_nbits-1:0] up_rdy;

  logic [(1<<A)-1:0]               pending;
  logic [(1<<A)-1:0]               pending_nxt;

  logic [P-1:0]                    hazard;
  logic [P-1:0]                    rd_pend;
  logic [P-1:0][c_sel_nbits-1:0]   sel;
  logic [P-1:0][D-1:0]             data;

  logic stall;
  logic issue_fwd;
  logic issue_set;
  logic waw;

  // Register 0 is never tracked, so writes to it neither enter the
  // stage pipe nor set a pending bit.
  assign issue_fwd = bus.issue_val & bus.issue_wen & ~bus.issue_long & ~stall
                   & (bus.issue_waddr != '0);
  assign issue_set = bus.issue_val & bus.issue_wen &  bus.issue_long & ~stall
                   & (bus.issue_waddr != '0);

  // Upstream view of each stage: stage 0 is fed by the issuing instruction.
  always_comb begin
    up_val      = '0;
    up_waddr    = '0;
    up_rdy      = '0;
    up_val[0]   = issue_fwd;
    up_waddr[0] = bus.issue_waddr;
    up_rdy[0]   = bus.issue_rdy_stage;
    for (int unsigned s = 1; s < S; s++) begin
      up_val[s]   = ent_val[s-1];
      up_waddr[s] = ent_waddr[s-1];
      up_rdy[s]   = ent_rdy[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_val   <= '0;
      ent_waddr <= '0;
      ent_rdy   <= '0;
    end else begin
      for (int unsigned s = 0; s < S; s++) begin
        if (bus.squash[s]) begin
          ent_val[s] <= 1'b0;
        end else if (bus.stage_en[s]) begin
          ent_val[s]   <= up_val[s];
          ent_waddr[s] <= up_waddr[s];
          ent_rdy[s]   <= up_rdy[s];
        end
      end
    end
  end

  // Clear first so a same-cycle set to the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (bus.long_wb_val) pending_nxt[bus.long_wb_addr] = 1'b0;
    if (issue_set)       pending_nxt[bus.issue_waddr]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  for (genvar p = 0; p < P; p++) begin : g_port
    plab2_proc_bypass_match #(
      .p_num_stages  (S),
      .p_addr_nbits  (A),
      .p_data_nbits  (D),
      .p_stage_nbits (c_stage_nbits),
      .p_sel_nbits   (c_sel_nbits)
    ) u_match (
      .ent_val   (ent_val),
      .ent_waddr (ent_waddr),
      .ent_rdy   (ent_rdy),
      .rd_addr   (bus.rd_addr[p*A +: A]),
      .rf_rdata  (bus.rf_rdata[p*D +: D]),
      .byp_data  (bus.byp_data),
      .sel       (sel[p]),
      .hazard    (hazard[p]),
      .data      (data[p])
    );
    assign rd_pend[p] = pending[bus.rd_addr[p*A +: A]];
  end

  assign waw   = bus.issue_val & bus.issue_wen & pending[bus.issue_waddr];
  assign stall = (|(bus.rd_val & (hazard | rd_pend))) | waw;

  assign bus.rd_data = data;
  assign bus.byp_sel = sel;
  assign bus.stall_D = stall;
  assign bus.pending = pending;

endmodule

// File: tb/tb_plab2_proc_bypass_scoreboard.sv
module tb_plab2_proc_bypass_scoreboard;
  import plab2_proc_bypass_pkg::*;

  localparam int unsigned S    = 3;
  localparam int unsigned P    = 2;
  localparam int unsigned A    = 5;
  localparam int unsigned D    = 32;
  localparam int unsigned SELN = clog2(S + 1);

  logic clk;
  logic reset;

  plab2_proc_bypass_scoreboard_if #(
    .p_num_stages(S), .p_num_rd_ports(P), .p_addr_nbits(A), .p_data_nbits(D)
  ) bus ();

  plab2_proc_bypass_scoreboard #(
    .p_num_stages(S), .p_num_rd_ports(P), .p_addr_nbits(A), .p_data_nbits(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: list of in-flight writes by stage plus a pending set.
  int          m_val  [S];
  int          m_addr [S];
  int          m_rdy  [S];
  logic [31:0] m_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < S; s++) begin
      m_val[s] = 0; m_addr[s] = 0; m_rdy[s] = 0;
    end
    m_pend = '0;
  endtask

  task automatic idle();
    bus.domain          = 1'b0;
    bus.issue_val       = 1'b0;
    bus.issue_wen       = 1'b0;
    bus.issue_waddr     = '0;
    bus.issue_rdy_stage = '0;
    bus.issue_long      = 1'b0;
    bus.stage_en        = '1;
    bus.squash          = '0;
    bus.rd_val          = '0;
    bus.rd_addr         = '0;
    bus.long_wb_val     = 1'b0;
    bus.long_wb_addr    = '0;
    for (int p = 0; p < P; p++) bus.rf_rdata[p*D +: D] = $urandom;
    for (int s = 0; s < S; s++) bus.byp_data[s*D +: D] = $urandom;
  endtask

  task automatic issue(input int addr, input int rdy, input bit is_long);
    bus.issue_val       = 1'b1;
    bus.issue_wen       = 1'b1;
    bus.issue_waddr     = A'(addr);
    bus.issue_rdy_stage = 2'(rdy);
    bus.issue_long      = is_long;
  endtask

  task automatic rd(input int p, input int addr);
    bus.rd_val[p]          = 1'b1;
    bus.rd_addr[p*A +: A]  = A'(addr);
  endtask

  // Check combinational outputs against the reference, then clock once
  // and advance the reference.
  task automatic step();
    bit   stall;
    bit   haz;
    int   sel;
    int   ra;
    int   nv[S];
    int   na[S];
    int   nr[S];
    logic [D-1:0] data;
    #1;
    stall = 0;
    for (int p = 0; p < P; p++) begin
      ra   = int'(bus.rd_addr[p*A +: A]);
      sel  = 0;
      data = bus.rf_rdata[p*D +: D];
      haz  = 0;
      for (int s = 0; s < S; s++) begin
        if (sel == 0 && m_val[s] != 0 && m_addr[s] == ra && ra != 0) begin
          sel  = s + 1;
          data = bus.byp_data[s*D +: D];
          haz  = (m_rdy[s] > s);
        end
      end
      if (bus.rd_val[p] && (haz || m_pend[ra])) stall = 1;
      chk($sformatf("byp_sel[%0d]", p), 64'(bus.byp_sel[p*SELN +: SELN]), 64'(sel));
      chk($sformatf("rd_data[%0d]", p), 64'(bus.rd_data[p*D +: D]), 64'(data));
    end
    if (bus.issue_val && bus.issue_wen && m_pend[bus.issue_waddr]) stall = 1;
    chk("stall_D", 64'(bus.stall_D), 64'(stall));
    chk("pending", 64'(bus.pending), 64'(m_pend));
    @(posedge clk);
    for (int s = 0; s < S; s++) begin
      nv[s] = m_val[s]; na[s] = m_addr[s]; nr[s] = m_rdy[s];
      if (bus.squash[s]) nv[s] = 0;
      else if (bus.stage_en[s]) begin
        if (s == 0) begin
          nv[0] = (bus.issue_val && bus.issue_wen && !bus.issue_long && !stall
                   && bus.issue_waddr != 0) ? 1 : 0;
          na[0] = int'(bus.issue_waddr);
          nr[0] = int'(bus.issue_rdy_stage);
        end else begin
          nv[s] = m_val[s-1]; na[s] = m_addr[s-1]; nr[s] = m_rdy[s-1];
        end
      end
    end
    m_val = nv; m_addr = na; m_rdy = nr;
    if (bus.long_wb_val) m_pend[bus.long_wb_addr] = 1'b0;
    if (bus.issue_val && bus.issue_wen && bus.issue_long && !stall && bus.issue_waddr != 0)
      m_pend[bus.issue_waddr] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset stall_D", 64'(bus.stall_D), 64'd0);
    chk("reset pending", 64'(bus.pending), 64'd0);
    step();

    // ADD r3 then dependent read: forwarded from X
    idle(); issue(3, 0, 0); step();
    idle(); rd(0, 3); bus.byp_data[0 +: D] = 32'h0000_0007;
    #1;
    chk("add sel", 64'(bus.byp_sel[0 +: SELN]), 64'd1);
    chk("add data", 64'(bus.rd_data[0 +: D]), 64'h7);
    chk("add stall", 64'(bus.stall_D), 64'd0);
    step();

    // LW r4 ready in M: one stall cycle, then forward from M
    idle(); issue(4, 1, 0); step();
    idle(); rd(0, 4);
    #1; chk("lw stall", 64'(bus.stall_D), 64'd1);
    step();
    idle(); rd(0, 4); bus.byp_data[D +: D] = 32'hDEAD_BEEF;
    #1;
    chk("lw stall2", 64'(bus.stall_D), 64'd0);
    chk("lw sel", 64'(bus.byp_sel[0 +: SELN]), 64'd2);
    chk("lw data", 64'(bus.rd_data[0 +: D]), 64'hDEAD_BEEF);
    step();

    // r5 in X and W: youngest wins; r0 never forwarded
    idle(); issue(5, 0, 0); step();
    idle(); issue(1, 0, 0); step();
    idle(); issue(5, 0, 0); step();
    idle(); rd(0, 5); rd(1, 0); issue(0, 0, 0);
    bus.rf_rdata[D +: D] = '0;
    #1;
    chk("young sel", 64'(bus.byp_sel[0 +: SELN]), 64'd1);
    chk("young data", 64'(bus.rd_data[0 +: D]), 64'(bus.byp_data[0 +: D]));
    chk("r0 sel", 64'(bus.byp_sel[SELN +: SELN]), 64'd0);
    chk("r0 data", 64'(bus.rd_data[D +: D]), 64'd0);
    step();

    // MUL r6 long latency: reader and WAW stall until after writeback
    idle(); issue(6, 0, 1); step();
    idle(); rd(0, 6);
    #1;
    chk("mul pend", 64'(bus.pending[6]), 64'd1);
    chk("mul stall", 64'(bus.stall_D), 64'd1);
    step();
    idle(); issue(6, 0, 0);
    #1; chk("waw stall", 64'(bus.stall_D), 64'd1);
    step();
    idle(); rd(0, 6); bus.long_wb_val = 1'b1; bus.long_wb_addr = 5'd6;
    #1; chk("wb cycle stall", 64'(bus.stall_D), 64'd1);
    step();
    idle(); rd(0, 6);
    #1;
    chk("mul release", 64'(bus.stall_D), 64'd0);
    chk("mul pend clr", 64'(bus.pending[6]), 64'd0);
    chk("mul sel", 64'(bus.byp_sel[0 +: SELN]), 64'd0);
    step();

    // Squash ADD r7 in X while older stages hold
    idle(); issue(7, 0, 0); step();
    idle(); bus.squash = 3'b001; bus.stage_en = 3'b001; step();
    idle(); rd(0, 7);
    #1; chk("squash sel", 64'(bus.byp_sel[0 +: SELN]), 64'd0);
    step();

    // Reset with three valid entries discards all of them
    idle(); issue(1, 0, 0); step();
    idle(); issue(2, 2, 0); step();
    idle(); issue(3, 0, 0); step();
    idle(); rd(0, 1); rd(1, 2);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst sel0", 64'(bus.byp_sel[0 +: SELN]), 64'd0);
    chk("rst sel1", 64'(bus.byp_sel[SELN +: SELN]), 64'd0);
    chk("rst stall", 64'(bus.stall_D), 64'd0);
    chk("rst data0", 64'(bus.rd_data[0 +: D]), 64'(bus.rf_rdata[0 +: D]));
    chk("rst data1", 64'(bus.rd_data[D +: D]), 64'(bus.rf_rdata[D +: D]));
    step();

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      idle();
      bus.stage_en = S'($urandom);
      if ($urandom_range(0, 7) == 0) bus.squash = S'($urandom);
      for (int p = 0; p < P; p++) begin
        bus.rd_val[p]         = $urandom_range(0, 1);
        bus.rd_addr[p*A +: A] = A'($urandom_range(0, 7));
      end
      bus.issue_val       = $urandom_range(0, 1);
      bus.issue_wen       = ($urandom_range(0, 3) != 0);
      bus.issue_waddr     = A'($urandom_range(0, 7));
      bus.issue_rdy_stage = 2'($urandom_range(0, 3));
      bus.issue_long      = ($urandom_range(0, 7) == 0);
      bus.long_wb_val     = ($urandom_range(0, 4) == 0);
      bus.long_wb_addr    = A'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
